// File: rtl/tqvp_meiniki_waveforms_pkg.sv
// tqvp_meiniki_waveforms_pkg: shared draw FSM states, register map and SSD1306 byte constants
package tqvp_meiniki_waveforms_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR_CMD, S_ADDR_PG0, S_ADDR_PG1, S_PIXEL, S_NEXT_CH} draw_state_t;
  localparam logic [3:0] ADDR_SPI = 4'h0;
  localparam logic [3:0] ADDR_CFG = 4'h1;
  localparam logic [3:0] ADDR_CHMASK = 4'h2;
  localparam logic [3:0] ADDR_SDIV = 4'h3;
  localparam logic [3:0] ADDR_CTRL = 4'h4;
  localparam logic [3:0] ADDR_TRIG = 4'h5;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
  localparam logic [7:0] PX_HIGH = 8'h80;
  localparam logic [7:0] PX_LOW = 8'h01;
  // Lowest set bit of mask at or above from; 8 means none.
  function automatic logic [3:0] next_ch(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--) if (mask[i] && 4'(i) >= from) r = 4'(i);
    return r;
  endfunction
endpackage

// File: rtl/tqvp_meiniki_spi_byte_tx.sv
// tqvp_meiniki_spi_byte_tx: MSB-first SPI byte transmitter, 16 half-bit phases of presc+1 clocks
// Ports: clk, rst_n (async, active-low); presc, start, byte_in in; sck, mosi, busy, done (1-cycle) out.
module tqvp_meiniki_spi_byte_tx #(
  parameter bit CPOL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] presc,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       done
);
  logic [3:0] div, ph;
  logic [7:0] sh;
  logic adv;
  assign adv = busy && div == presc;
  assign mosi = busy && sh[7];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      sck <= CPOL;
      div <= '0;
      ph <= '0;
      sh <= '0;
    end else begin
      done <= adv && ph == 4'd15;
      if (start && !busy) begin
        busy <= 1'b1;
        sh <= byte_in;
        div <= '0;
        ph <= '0;
        sck <= CPOL;
      end else if (busy) begin
        div <= adv ? 4'd0 : div + 4'd1;
        if (adv) begin
          ph <= ph + 4'd1;
          sck <= ph == 4'd15 ? CPOL : ~sck;
          if (ph[0]) sh <= {sh[6:0], 1'b0};
          if (ph == 4'd15) busy <= 1'b0;
        end
      end
    end
endmodule

// File: rtl/tqvp_meiniki_waveforms_mc.sv
// tqvp_meiniki_waveforms_mc: multi-channel sampler that plots each channel to its own SSD1306 page over SPI
// Ports: clk, rst_n (async, active-low); ui_in sampled pins; uo_out {DC,CS_N,MOSI,SCK} at [4:1];
//        address/data_write/data_in TinyQV write bus; data_out combinational read of STATUS.
// Optional: define WAVEFORMS_TRIGGER_EN to add the edge trigger register (0x5) and STATUS[7]=armed.
module tqvp_meiniki_waveforms_mc
  import tqvp_meiniki_waveforms_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PAGE_BASE = 0,
  parameter bit CPOL = 1'b0,
  parameter int SDIV_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);
  draw_state_t state, state_n;
  logic [3:0] presc, first_ch, nxt_ch;
  logic dc_cfg, cs_cfg, run, stop_req, overrun, pending, issued, armed;
  logic [NUM_CH-1:0] chmask, fmask;
  logic [SDIV_W-1:0] sdiv, dcnt;
  logic [2:0] cur_ch, px_idx, scnt;
  logic [7:0][7:0] sh, sh_n, fbuf;
  logic [7:0] smp, tx_byte, status;
  logic tx_start, tx_busy, tx_done, tx_sck, tx_mosi;
  logic idle, cpu_spi, ctrl_wr, do_start, do_stop, stop_now, tick, capture, blk_done;
  logic frame_go, frame_end, pend_clr;
  logic unused_in;
  assign unused_in = ^ui_in;
  assign idle = state == S_IDLE && !tx_busy;
  assign cpu_spi = data_write && address == ADDR_SPI && idle;
  assign ctrl_wr = data_write && address == ADDR_CTRL;
  assign do_stop = ctrl_wr && data_in[1];
  assign do_start = ctrl_wr && data_in[0] && !data_in[1];
  // A stop requested mid-frame lands on the frame's last cycle so no block can sneak in afterwards.
  assign stop_now = (do_stop && state == S_IDLE) || ((stop_req || do_stop) && frame_end);
  assign smp = 8'(ui_in[NUM_CH-1:0]);
  assign first_ch = next_ch(8'(chmask), 4'd0);
  assign nxt_ch = next_ch(8'(fmask), {1'b0, cur_ch} + 4'd1);
  // A CPU byte issued this cycle takes the transmitter; the pending frame waits for its done.
  assign frame_go = state == S_IDLE && pending && !tx_busy && !cpu_spi;
  assign frame_end = state == S_NEXT_CH && nxt_ch[3];
  assign pend_clr = (frame_go && chmask == '0) || frame_end;
  assign tick = run && dcnt == sdiv;
  assign blk_done = capture && scnt == 3'd7;
  always_comb for (int i = 0; i < 8; i++) sh_n[i] = {sh[i][6:0], smp[i]};
`ifdef WAVEFORMS_TRIGGER_EN
  logic [2:0] trig_ch;
  logic trig_edge, trig_en, prev;
  // Capture opens on the first tick where the selected pin moved to the chosen level since the last tick.
  assign capture = tick && (!armed || (ui_in[trig_ch] == trig_edge && prev != trig_edge));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {trig_en, trig_edge, trig_ch} <= '0;
      armed <= 1'b0;
      prev <= 1'b0;
    end else begin
      if (data_write && address == ADDR_TRIG) {trig_en, trig_edge, trig_ch} <= data_in[4:0];
      prev <= do_start || tick ? ui_in[trig_ch] : prev;
      armed <= do_start ? trig_en : (!run || capture) ? 1'b0 : armed;
    end
`else
  assign armed = 1'b0;
  assign capture = tick;
`endif
  always_comb begin
    state_n = state;
    tx_start = 1'b0;
    tx_byte = data_in;
    case (state)
      S_IDLE: begin
        tx_start = cpu_spi;
        if (frame_go && chmask != '0) state_n = S_ADDR_CMD;
      end
      S_ADDR_CMD: begin
        tx_byte = CMD_PAGE_ADDR;
        tx_start = !issued;
        if (tx_done) state_n = S_ADDR_PG0;
      end
      S_ADDR_PG0, S_ADDR_PG1: begin
        tx_byte = 8'(PAGE_BASE) + 8'(cur_ch);
        tx_start = !issued;
        if (tx_done) state_n = state == S_ADDR_PG0 ? S_ADDR_PG1 : S_PIXEL;
      end
      S_PIXEL: begin
        tx_byte = fbuf[cur_ch][~px_idx] ? PX_HIGH : PX_LOW;
        tx_start = !issued;
        if (tx_done && px_idx == 3'd7) state_n = S_NEXT_CH;
      end
      S_NEXT_CH: state_n = nxt_ch[3] ? S_IDLE : S_ADDR_CMD;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc <= 4'd4;
      dc_cfg <= 1'b0;
      cs_cfg <= 1'b1;
      chmask <= '1;
      fmask <= '1;
      sdiv <= '0;
      dcnt <= '0;
      run <= 1'b0;
      stop_req <= 1'b0;
      overrun <= 1'b0;
      pending <= 1'b0;
      issued <= 1'b0;
      cur_ch <= '0;
      px_idx <= '0;
      scnt <= '0;
      sh <= '0;
      fbuf <= '0;
    end else begin
      issued <= tx_start ? 1'b1 : tx_done ? 1'b0 : issued;
      if (data_write && address == ADDR_CFG && idle) {cs_cfg, dc_cfg, presc} <= data_in[5:0];
      if (data_write && address == ADDR_CHMASK) chmask <= data_in[NUM_CH-1:0];
      if (data_write && address == ADDR_SDIV) sdiv <= SDIV_W'(data_in);
      run <= stop_now ? 1'b0 : do_start ? 1'b1 : run;
      stop_req <= (stop_now || do_start) ? 1'b0 : do_stop ? 1'b1 : stop_req;
      dcnt <= (!run || do_start || tick) ? '0 : dcnt + SDIV_W'(1);
      scnt <= do_start ? 3'd0 : capture ? scnt + 3'd1 : scnt;
      if (capture) sh <= sh_n;
      if (blk_done && !pending) fbuf <= sh_n;
      overrun <= do_start ? 1'b0 : (blk_done && pending) ? 1'b1 : overrun;
      pending <= (blk_done && !pending) ? 1'b1 : pend_clr ? 1'b0 : pending;
      if (frame_go) begin
        fmask <= chmask;
        cur_ch <= first_ch[2:0];
      end else if (state == S_NEXT_CH && !nxt_ch[3]) cur_ch <= nxt_ch[2:0];
      if (state == S_PIXEL && tx_done) px_idx <= px_idx + 3'd1;
    end
  tqvp_meiniki_spi_byte_tx #(.CPOL(CPOL)) u_tx (
    .clk(clk),
    .rst_n(rst_n),
    .presc(presc),
    .start(tx_start),
    .byte_in(tx_byte),
    .sck(tx_sck),
    .mosi(tx_mosi),
    .busy(tx_busy),
    .done(tx_done)
  );
  assign status = {armed, cur_ch, pending, overrun, run, idle};
  assign data_out = address == ADDR_STATUS ? status : 8'h00;
  assign uo_out = {3'b000, state == S_IDLE ? dc_cfg : state == S_PIXEL,
                   cs_cfg & ~(tx_busy | (state != S_IDLE)), tx_mosi, tx_sck, 1'b0};
endmodule

// File: tb/tb_tqvp_meiniki_waveforms_mc.sv
// tb_tqvp_meiniki_waveforms_mc: randomized scoreboard bench decoding the SPI stream back into {DC,byte}
module tb_tqvp_meiniki_waveforms_mc;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] ui_in, uo_out, data_in, data_out;
  logic [3:0] address;
  logic data_write;
  int tests = 0, fails = 0, bytes_seen = 0;
  logic [8:0] exp_q[$];

  tqvp_meiniki_waveforms_mc dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_write(data_write), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: rebuild each byte from MOSI at SCK rising edges, then pop and compare.
  int bitcnt = 0;
  logic [7:0] shr = '0;
  logic prev_sck = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bitcnt = 0;
      prev_sck = 1'b0;
    end else begin
      if (uo_out[1] && !prev_sck) begin
        shr = {shr[6:0], uo_out[2]};
        bitcnt++;
        if (bitcnt == 8) begin
          bitcnt = 0;
          bytes_seen++;
          if (exp_q.size() == 0) chk("spi_unexpected_byte", {uo_out[4], shr}, 9'h1ff);
          else chk("spi_byte", {uo_out[4], shr}, exp_q.pop_front());
        end
      end
      prev_sck = uo_out[1];
    end
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a;
    data_in = d;
    data_write = 1'b1;
    @(posedge clk);
    #1 data_write = 1'b0;
    address = 4'h8;
  endtask

  // Reference: channel c goes to page c with 0x22,c,c then one byte per sample, oldest first.
  function automatic void push_frame(input logic [3:0] mask, input logic [7:0] pats[8]);
    for (int c = 0; c < 4; c++)
      if (mask[c]) begin
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b0, 8'(c)});
        exp_q.push_back({1'b0, 8'(c)});
        for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, pats[k][c] ? 8'h80 : 8'h01});
      end
  endfunction

  // Start a run, present pats[k] for the k-th captured tick (after pre idle ticks), then stop.
  task automatic drive_block(input int sd, input logic [7:0] pats[8], input int pre, input logic [7:0] pre_val);
    ui_in = pre > 0 ? pre_val : pats[0];
    wr(4'h4, 8'h01);
    for (int m = 0; m < pre; m++) begin
      repeat (sd + 1) @(posedge clk);
      #1;
      if (m == 0) chk("armed_while_waiting", data_out[7], 1);
      if (m == pre - 1) ui_in = pats[0];
    end
    for (int k = 0; k < 8; k++) begin
      repeat (sd + 1) @(posedge clk);
      #1;
      if (k < 7) ui_in = pats[k + 1];
    end
    wr(4'h4, 8'h02);
    if (pre > 0) chk("armed_cleared", data_out[7], 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || data_out[0] !== 1'b1 || data_out[3] !== 1'b0) && n < 20000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_in_time", int'(n < 20000), 1);
  endtask

  initial begin
    logic [7:0] pats[8];
    int cnt, run_len, max_run, seen, act;
    rst_n = 1'b0;
    ui_in = '0;
    address = 4'h8;
    data_in = '0;
    data_write = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_uo_out", uo_out, 8'h08);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("reset_status", data_out, 8'h01);
    address = 4'h3;
    #1 chk("unmapped_read", data_out, 8'h00);
    address = 4'h8;

    // Raw CPU byte at reset prescaler: CS_N low for exactly 80 clocks.
    exp_q.push_back({1'b0, 8'hA5});
    wr(4'h0, 8'hA5);
    cnt = 0;
    while (uo_out[3] == 1'b0 && cnt < 1000) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("raw_byte_cs_low_clocks", cnt, 80);
    repeat (4) @(posedge clk);
    #1 chk("raw_byte_idle_lines", uo_out, 8'h08);
    chk("raw_byte_consumed", exp_q.size(), 0);

    // Frames: the first uses the fixed scenario, the rest are random.
    for (int it = 0; it < 5; it++) begin
      int pr, mk, sd;
      pr = it == 0 ? 1 : $urandom_range(0, 3);
      mk = it == 0 ? 5 : $urandom_range(1, 15);
      sd = it == 0 ? 3 : $urandom_range(0, 5);
      for (int k = 0; k < 8; k++) pats[k] = it == 0 ? 8'h01 : 8'($urandom);
      wr(4'h1, 8'(8'h20 | pr));
      wr(4'h2, 8'(mk));
      wr(4'h3, 8'(sd));
      push_frame(4'(mk), pats);
      drive_block(sd, pats, 0, 8'h00);
      wait_drain();
      chk("frame_no_overrun", data_out[2], 0);
      chk("frame_run_stopped", data_out[1], 0);
    end

    // Overrun: slow SPI, fast sampling; later blocks must be dropped, not drawn.
    wr(4'h1, 8'h2F);
    wr(4'h2, 8'h01);
    wr(4'h3, 8'h00);
    for (int k = 0; k < 8; k++) pats[k] = 8'h01;
    push_frame(4'h1, pats);
    ui_in = 8'h01;
    wr(4'h4, 8'h01);
    repeat (8) @(posedge clk);
    #1 ui_in = 8'h00;
    repeat (50) @(posedge clk);
    #1 chk("overrun_set_midframe", data_out[2], 1);
    wr(4'h4, 8'h02);
    wait_drain();
    chk("overrun_sticky", data_out[2], 1);
    chk("overrun_run_stopped", data_out[1], 0);
    wr(4'h4, 8'h01);
    wr(4'h4, 8'h02);
    chk("overrun_cleared_by_start", data_out[2], 0);

    // Empty channel mask: pending pulses for one cycle, bus stays quiet.
    wr(4'h1, 8'h21);
    wr(4'h2, 8'h00);
    wr(4'h4, 8'h01);
    run_len = 0;
    max_run = 0;
    seen = 0;
    act = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      run_len = data_out[3] ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      if (data_out[3]) seen++;
      if (uo_out != 8'h08) act++;
    end
    wr(4'h4, 8'h02);
    chk("chmask0_pending_max_run", max_run, 1);
    chk("chmask0_spi_quiet", act, 0);
    chk("chmask0_pending_seen", int'(seen > 3), 1);

`ifdef WAVEFORMS_TRIGGER_EN
    wr(4'h5, 8'h19);
    wr(4'h2, 8'h02);
    wr(4'h3, 8'h03);
    wr(4'h1, 8'h20);
    for (int k = 0; k < 8; k++) pats[k] = 8'($urandom);
    pats[0][1] = 1'b1;
    push_frame(4'h2, pats);
    drive_block(3, pats, 5, 8'($urandom) & 8'hFD);
    wait_drain();
    wr(4'h5, 8'h00);
`else
    wr(4'h5, 8'h1F);
    wr(4'h4, 8'h01);
    #1 chk("trig_absent_status7", data_out[7], 0);
    wr(4'h4, 8'h02);
`endif

    // Reset in the middle of the 5th pixel byte.
    wr(4'h1, 8'h21);
    wr(4'h2, 8'h01);
    wr(4'h3, 8'h01);
    for (int k = 0; k < 8; k++) pats[k] = 8'($urandom);
    push_frame(4'h1, pats);
    cnt = bytes_seen;
    drive_block(1, pats, 0, 8'h00);
    act = 0;
    while (bytes_seen < cnt + 7 && act < 5000) begin
      @(posedge clk);
      #1 act++;
    end
    chk("reached_pixel5", int'(bytes_seen >= cnt + 7), 1);
    repeat (10) @(posedge clk);
    #1 chk("pixel5_dc_cs", uo_out[4:3], 2'b10);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_lines", uo_out, 8'h08);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_reset_status", data_out, 8'h01);
    repeat (200) @(posedge clk);
    #1 chk("post_reset_quiet", uo_out, 8'h08);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
